mandelbrot_pixel_dispatcher: RTL and testbench
==============================================

Name: mandelbrot_pixel_dispatcher

Overview:
- Work-issue front end for the Mandelbrot pipeline core; drives its write_request_in / re_in / im_in / pixel_addr_in / max_iterations_in / calculating inputs.
- On a start pulse it scans one frame in raster order (x fastest, top row first).
- For each pixel it generates fixed-point complex coordinates incrementally and issues one write request per pixel, throttled by the core's buffer_full_out.
- Signals frame completion to the frame-control logic.

Parameters:
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- ADDR_W, 22, pixel address width; H_RES*V_RES must be no greater than 2^ADDR_W.
- COORD_W, 32, width of re/im/step in two's-complement fixed point (format opaque to this block).
- ITER_W, 11, max-iterations width.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches frame setup and begins scan (ignored unless IDLE or DONE).
- abort  input  1  one-cycle pulse; stops scan and returns to IDLE.
- enable  input  1  pause control; 0 freezes issue without losing position.
- re_start_in  input  COORD_W  real coordinate of pixel (0,0).
- im_start_in  input  COORD_W  imaginary coordinate of pixel (0,0).
- step_in  input  COORD_W  coordinate delta per pixel, both axes.
- max_iterations_in  input  ITER_W  iteration limit for this frame.
- buffer_full_in  input  1  core input buffer almost-full; guarantees at least 2 free slots while low.
- write_request_out  output  1  one-cycle request; the core accepts every asserted cycle.
- re_out  output  COORD_W  real coordinate of the issued pixel.
- im_out  output  COORD_W  imaginary coordinate of the issued pixel.
- pixel_addr_out  output  ADDR_W  linear address y*H_RES+x.
- max_iterations_out  output  ITER_W  latched limit.
- calculating_out  output  1  high from start accept until DONE/IDLE.
- busy_out  output  1  high in RUN.
- frame_done_out  output  1  one-cycle pulse when the last pixel is issued.

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters x,y = 0; accumulators 0.
- States:
  - IDLE --start--> RUN.
  - RUN --last pixel issued--> DONE.
  - DONE --start--> RUN.
  - Any state --abort--> IDLE.
- start accept (in IDLE or DONE): latch re_start, im_start, step, max_iterations. Set re_acc=re_start, im_acc=im_start, x=0, y=0, addr=0. calculating_out=1 from the next cycle.
- Issue condition, cycle N: state==RUN && enable && !buffer_full_in. All outputs are registered.
  - Cycle N+1: write_request_out=1; re_out/im_out/pixel_addr_out carry the current pixel.
  - Counters then advance. First request appears 2 cycles after the start pulse if unthrottled.
  - Peak throughput is 1 pixel/cycle.
- Advance rules:
  - Mid-row: x+1; re_acc += step; addr+1.
  - Row end (x==H_RES-1): x=0; re_acc=re_start; y+1; im_acc -= step (top row = largest im); addr+1.
- Arithmetic: all adds and subtracts are modulo 2^COORD_W; no saturation. Overflow wraps silently.
- Last pixel (x==H_RES-1, y==V_RES-1):
  - Its request cycle also pulses frame_done_out.
  - State moves to DONE in the same cycle.
  - calculating_out and busy_out drop one cycle later.
- buffer_full_in high, or enable low: write_request_out=0 next cycle; counters hold. No pixel is skipped or duplicated.
- abort during RUN:
  - Pending registered request, if any, still completes that cycle.
  - Next cycle: IDLE, calculating_out=0, no frame_done_out.
- abort and start in the same cycle: abort wins.
- start during RUN: ignored.
- max_iterations_out holds its latched value through DONE; it clears only on reset.
- Reset mid-scan: immediate return to reset values; no partial frame_done_out.

Optional Feature:
- Macro: MANDELBROT_DISPATCH_STALL_CNT_EN.
- Enabled:
  - Adds output stall_count_out, 32 bits.
  - Counts cycles with state==RUN && (buffer_full_in || !enable).
  - Cleared on reset and on start accept; saturates at 0xFFFFFFFF; holds after DONE.
- Disabled: port and counter absent; behaviour otherwise identical.

Test Plan:
- Small frame, H_RES=4, V_RES=3, re_start=0x1000, im_start=0x2000, step=0x10, buffer_full_in=0 -> 12 consecutive requests starting 2 cycles after start.
  - Addresses 0..11.
  - Addr 3: re=0x1030. Addr 4: re=0x1000, im=0x1FF0. Addr 11: im=0x1FE0.
  - frame_done_out pulses with addr 11.
- Hold buffer_full_in high for 5 cycles mid-row at addr 6 -> no requests for 5 cycles; next request is addr 6 or 7 exactly as sequenced, no gaps or repeats in the address stream.
- abort after addr 5 issued -> no further requests; calculating_out=0 next cycle; frame_done_out never pulses. New start yields addr 0 again.
- re_start=0x7FFFFFF0, step=0x10 -> re at x=1 equals 0x80000000 (wrap, no saturation).
- Assert reset asynchronously mid-frame, between clock edges -> all outputs 0 immediately; start after release rescans from addr 0.
- With MANDELBROT_DISPATCH_STALL_CNT_EN: enable low for 7 RUN cycles plus buffer_full_in high for 3 -> stall_count_out=10 at DONE; start clears it to 0.

Source files
------------

// File: rtl/mandelbrot_pixel_dispatcher.sv
// Raster-order pixel work issuer for the Mandelbrot core: incremental coordinates, throttled requests.
// Optional stall counter output is built when MANDELBROT_DISPATCH_STALL_CNT_EN is defined.
module mandelbrot_pixel_dispatcher #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned COORD_W = 32,
  parameter int unsigned ITER_W  = 11
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               enable,
  input  logic [COORD_W-1:0] re_start_in,
  input  logic [COORD_W-1:0] im_start_in,
  input  logic [COORD_W-1:0] step_in,
  input  logic [ITER_W-1:0]  max_iterations_in,
  input  logic               buffer_full_in,
  output logic               write_request_out,
  output logic [COORD_W-1:0] re_out,
  output logic [COORD_W-1:0] im_out,
  output logic [ADDR_W-1:0]  pixel_addr_out,
  output logic [ITER_W-1:0]  max_iterations_out,
  output logic               calculating_out,
  output logic               busy_out,
  output logic               frame_done_out
`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count_out
`endif
);

  localparam int unsigned X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state, state_d;
  logic [X_W-1:0]     x, x_d;
  logic [Y_W-1:0]     y, y_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [COORD_W-1:0] re_acc, re_acc_d, im_acc, im_acc_d;
  logic [COORD_W-1:0] re_base, re_base_d, step, step_d;
  logic               req_d, done_d, calc_d, busy_d;
  logic [COORD_W-1:0] re_out_d, im_out_d;
  logic [ADDR_W-1:0]  addr_out_d;
  logic [ITER_W-1:0]  iter_d;
  logic               issue, last_x, last_y;

  assign issue  = (state == ST_RUN) && enable && !buffer_full_in && !abort;
  assign last_x = (x == X_W'(H_RES - 1));
  assign last_y = (y == Y_W'(V_RES - 1));

  // Next-state and next-output logic; the current pixel is registered out as counters advance.
  always_comb begin
    state_d    = state;
    x_d        = x;
    y_d        = y;
    addr_d     = addr;
    re_acc_d   = re_acc;
    im_acc_d   = im_acc;
    re_base_d  = re_base;
    step_d     = step;
    req_d      = 1'b0;
    done_d     = 1'b0;
    calc_d     = calculating_out;
    busy_d     = busy_out;
    re_out_d   = re_out;
    im_out_d   = im_out;
    addr_out_d = pixel_addr_out;
    iter_d     = max_iterations_out;
    if (abort) begin
      state_d = ST_IDLE;
      calc_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          calc_d = 1'b0;
          busy_d = 1'b0;
          if (start) begin
            state_d   = ST_RUN;
            re_base_d = re_start_in;
            step_d    = step_in;
            iter_d    = max_iterations_in;
            re_acc_d  = re_start_in;
            im_acc_d  = im_start_in;
            x_d       = '0;
            y_d       = '0;
            addr_d    = '0;
            calc_d    = 1'b1;
            busy_d    = 1'b1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            req_d      = 1'b1;
            re_out_d   = re_acc;
            im_out_d   = im_acc;
            addr_out_d = addr;
            addr_d     = addr + ADDR_W'(1);
            if (last_x) begin
              // Rows descend in the imaginary axis: the top row carries the largest im.
              x_d      = '0;
              y_d      = y + Y_W'(1);
              re_acc_d = re_base;
              im_acc_d = im_acc - step;
              if (last_y) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              x_d      = x + X_W'(1);
              re_acc_d = re_acc + step;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          calc_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      x                  <= '0;
      y                  <= '0;
      addr               <= '0;
      re_acc             <= '0;
      im_acc             <= '0;
      re_base            <= '0;
      step               <= '0;
      write_request_out  <= 1'b0;
      frame_done_out     <= 1'b0;
      calculating_out    <= 1'b0;
      busy_out           <= 1'b0;
      re_out             <= '0;
      im_out             <= '0;
      pixel_addr_out     <= '0;
      max_iterations_out <= '0;
    end else begin
      state              <= state_d;
      x                  <= x_d;
      y                  <= y_d;
      addr               <= addr_d;
      re_acc             <= re_acc_d;
      im_acc             <= im_acc_d;
      re_base            <= re_base_d;
      step               <= step_d;
      write_request_out  <= req_d;
      frame_done_out     <= done_d;
      calculating_out    <= calc_d;
      busy_out           <= busy_d;
      re_out             <= re_out_d;
      im_out             <= im_out_d;
      pixel_addr_out     <= addr_out_d;
      max_iterations_out <= iter_d;
    end
  end

`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_d;

  // Saturating count of RUN cycles lost to back-pressure or pause.
  always_comb begin
    stall_d = stall_count_out;
    if (!abort && (state != ST_RUN) && start)
      stall_d = '0;
    else if ((state == ST_RUN) && (buffer_full_in || !enable) && (stall_count_out != 32'hFFFF_FFFF))
      stall_d = stall_count_out + 32'd1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) stall_count_out <= '0;
    else       stall_count_out <= stall_d;
  end
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_dispatcher.sv
// Directed self-checking bench for mandelbrot_pixel_dispatcher on a 4x3 frame.
// Stall-counter checks are built when MANDELBROT_DISPATCH_STALL_CNT_EN is defined.
module tb_mandelbrot_pixel_dispatcher;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] re_start_in = '0;
  logic [31:0] im_start_in = '0;
  logic [31:0] step_in = '0;
  logic [10:0] max_iterations_in = '0;
  logic        buffer_full_in = 1'b0;
  logic        write_request_out;
  logic [31:0] re_out, im_out;
  logic [21:0] pixel_addr_out;
  logic [10:0] max_iterations_out;
  logic        calculating_out, busy_out, frame_done_out;
`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_count_out;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] re_s, im_s, st;
  logic [10:0] mi;

  mandelbrot_pixel_dispatcher #(
    .H_RES(H), .V_RES(V), .ADDR_W(22), .COORD_W(32), .ITER_W(11)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .re_start_in(re_start_in), .im_start_in(im_start_in), .step_in(step_in),
    .max_iterations_in(max_iterations_in), .buffer_full_in(buffer_full_in),
    .write_request_out(write_request_out), .re_out(re_out), .im_out(im_out),
    .pixel_addr_out(pixel_addr_out), .max_iterations_out(max_iterations_out),
    .calculating_out(calculating_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
    , .stall_count_out(stall_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    re_start_in       = re_s;
    im_start_in       = im_s;
    step_in           = st;
    max_iterations_in = mi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected pixel a: re = re_s + x*step, im = im_s - y*step.
  task automatic expect_px(input int a);
    logic [31:0] er, ei;
    er = re_s + st * 32'(a % H);
    ei = im_s - st * 32'(a / H);
    check($sformatf("req[%0d]", a), 64'(write_request_out), 64'd1);
    check($sformatf("addr[%0d]", a), 64'(pixel_addr_out), 64'(a));
    check($sformatf("re[%0d]", a), 64'(re_out), 64'(er));
    check($sformatf("im[%0d]", a), 64'(im_out), 64'(ei));
    check($sformatf("done[%0d]", a), 64'(frame_done_out), (a == H * V - 1) ? 64'd1 : 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_req", 64'(write_request_out), 64'd0);
    check("rst_calc", 64'(calculating_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_addr", 64'(pixel_addr_out), 64'd0);
    check("rst_iter", 64'(max_iterations_out), 64'd0);
    reset = 1'b0;
    tick();

    // Full unthrottled frame
    re_s = 32'h1000; im_s = 32'h2000; st = 32'h10; mi = 11'd500;
    pulse_start();
    check("acc_calc", 64'(calculating_out), 64'd1);
    check("acc_req", 64'(write_request_out), 64'd0);
    tick();
    for (int a = 0; a < 12; a++) begin
      expect_px(a);
      check($sformatf("busy[%0d]", a), 64'(busy_out), 64'd1);
      if (a == 2) begin
        start = 1'b1;
        re_start_in = 32'hDEAD_BEEF;
        max_iterations_in = 11'd7;
      end
      tick();
      start = 1'b0;
    end
    check("fixed_re3", 64'(re_s + 32'h30), 64'h1030);
    check("post_req", 64'(write_request_out), 64'd0);
    check("post_done", 64'(frame_done_out), 64'd0);
    check("post_calc", 64'(calculating_out), 64'd0);
    check("post_busy", 64'(busy_out), 64'd0);
    check("iter_hold", 64'(max_iterations_out), 64'd500);

    // Back-pressure for 5 cycles after addr 6
    mi = 11'd33;
    pulse_start();
    tick();
    for (int a = 0; a < 7; a++) begin
      expect_px(a);
      if (a == 6) buffer_full_in = 1'b1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_req[%0d]", k), 64'(write_request_out), 64'd0);
      tick();
    end
    check("stall_req[4]", 64'(write_request_out), 64'd0);
    buffer_full_in = 1'b0;
    tick();
    for (int a = 7; a < 12; a++) begin
      expect_px(a);
      tick();
    end
    check("bp_iter", 64'(max_iterations_out), 64'd33);

    // Abort after addr 5
    pulse_start();
    tick();
    for (int a = 0; a < 6; a++) begin
      expect_px(a);
      if (a == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("abort_req", 64'(write_request_out), 64'd0);
    check("abort_calc", 64'(calculating_out), 64'd0);
    check("abort_busy", 64'(busy_out), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_idle_req[%0d]", k), 64'(write_request_out), 64'd0);
      check($sformatf("abort_idle_done[%0d]", k), 64'(frame_done_out), 64'd0);
      tick();
    end
    pulse_start();
    tick();
    expect_px(0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Coordinate wrap without saturation
    re_s = 32'h7FFF_FFF0; im_s = 32'h0000_0000; st = 32'h10;
    pulse_start();
    tick();
    check("wrap_re0", 64'(re_out), 64'h7FFF_FFF0);
    tick();
    check("wrap_re1", 64'(re_out), 64'h8000_0000);
    tick(); tick(); tick();
    check("wrap_im1", 64'(im_out), 64'hFFFF_FFF0);
    check("wrap_addr4", 64'(pixel_addr_out), 64'd4);

    // Asynchronous reset mid-frame, between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", 64'(write_request_out), 64'd0);
    check("arst_calc", 64'(calculating_out), 64'd0);
    check("arst_addr", 64'(pixel_addr_out), 64'd0);
    check("arst_re", 64'(re_out), 64'd0);
    check("arst_iter", 64'(max_iterations_out), 64'd0);
    #3;
    reset = 1'b0;
    tick();
    check("arst_idle", 64'(write_request_out), 64'd0);
    re_s = 32'h1000; im_s = 32'h2000; st = 32'h10;
    pulse_start();
    tick();
    expect_px(0);
    tick();
    expect_px(1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
    // 7 paused cycles plus 3 back-pressured cycles
    enable = 1'b0;
    pulse_start();
    check("sc_clear", 64'(stall_count_out), 64'd0);
    repeat (7) tick();
    enable = 1'b1;
    buffer_full_in = 1'b1;
    repeat (3) tick();
    buffer_full_in = 1'b0;
    for (int i = 0; i < 40 && !frame_done_out; i++) tick();
    check("sc_done_seen", 64'(frame_done_out), 64'd1);
    tick(); tick();
    check("sc_at_done", 64'(stall_count_out), 64'd10);
    pulse_start();
    check("sc_restart", 64'(stall_count_out), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
